market_stats_hub: RTL

Parametrised N-channel successor to the single-pair trading datapath. Compares buy/sell prices on each channel, keeps saturating per-channel and total trade counters with per-channel halt/resume, and holds a frame-synchronous snapshot for the VGA display so a frame never shows half-updated statistics. Sits between the order generators and `vga_display`; `frame_start` comes from `vga_controller`.

---
 rtl/market_pkg.sv | 22 ++
 rtl/trade_channel.sv | 73 +++++++
 rtl/market_stats_hub.sv | 81 ++++++++
 3 files changed

// File: rtl/market_pkg.sv
// Shared types and helpers for the market statistics hub.
// Holds default widths, the price type, popcount and bus slicing.
package market_pkg;

  localparam int DEF_PRICE_W = 8;
  localparam int DEF_CNT_W   = 8;

  typedef logic [DEF_PRICE_W-1:0] price_t;

  function automatic logic [3:0] popcount(input logic [7:0] v);
    logic [3:0] n;
    n = '0;
    for (int i = 0; i < 8; i++)
      n = n + {3'b000, v[i]};
    return n;
  endfunction

  function automatic int slice_lo(input int idx, input int w);
    return idx * w;
  endfunction

endpackage

// File: rtl/trade_channel.sv
// One trading channel: compare stage, saturating counter and halt.
// Resume clears the channel, including its stage-1 register.
module trade_channel
  import market_pkg::*;
#(
  parameter int PRICE_W    = DEF_PRICE_W,
  parameter int CNT_W      = DEF_CNT_W,
  parameter int HALT_LIMIT = 200
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               order_valid,
  input  logic [PRICE_W-1:0] buy_price,
  input  logic [PRICE_W-1:0] sell_price,
  input  logic               resume,
  output logic               inc,
  output logic [CNT_W-1:0]   count,
  output logic [PRICE_W-1:0] spread,
  output logic               halt
);

  logic               s1_valid;
  logic               s1_match;
  logic [PRICE_W-1:0] s1_spread;
  logic [CNT_W-1:0]   cnt_next;
  logic               halt_next;
  logic               accept;
  logic               ge;

  assign ge = buy_price >= sell_price;

  // Halt is decided from the post-increment count so a new order
  // arriving on the halting edge is already refused.
  always_comb begin
    inc      = s1_valid && s1_match && !halt;
    cnt_next = count;
    if (inc && count != '1)
      cnt_next = count + 1'b1;
    halt_next = halt || (cnt_next >= CNT_W'(HALT_LIMIT));
    accept    = order_valid && !halt_next;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_valid  <= 1'b0;
      s1_match  <= 1'b0;
      s1_spread <= '0;
      count     <= '0;
      spread    <= '0;
      halt      <= 1'b0;
    end else if (resume) begin
      s1_valid  <= 1'b0;
      s1_match  <= 1'b0;
      s1_spread <= '0;
      count     <= '0;
      spread    <= '0;
      halt      <= 1'b0;
    end else begin
      s1_valid <= accept;
      if (accept) begin
        s1_match  <= ge;
        s1_spread <= ge ? buy_price - sell_price
                        : sell_price - buy_price;
      end
      if (s1_valid && !halt) begin
        count  <= cnt_next;
        spread <= s1_spread;
      end
      halt <= halt_next;
    end
  end

endmodule

// File: rtl/market_stats_hub.sv
// N-channel trade statistics with a frame-synchronous snapshot.
// The snapshot copies live registers before same-edge updates.
module market_stats_hub
  import market_pkg::*;
#(
  parameter int N_CH       = 4,
  parameter int PRICE_W    = DEF_PRICE_W,
  parameter int CNT_W      = DEF_CNT_W,
  parameter int HALT_LIMIT = 200,
  parameter int TOT_W      = CNT_W + 3
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [N_CH-1:0]         order_valid,
  input  logic [N_CH*PRICE_W-1:0] buy_price,
  input  logic [N_CH*PRICE_W-1:0] sell_price,
  input  logic [N_CH-1:0]         resume,
  input  logic                    frame_start,
  output logic [N_CH*CNT_W-1:0]   snap_count,
  output logic [N_CH*PRICE_W-1:0] snap_spread,
  output logic [N_CH-1:0]         snap_halt,
  output logic [TOT_W-1:0]        snap_total,
  output logic                    snap_valid,
  output logic [N_CH-1:0]         halt
);

  logic [N_CH-1:0]         inc;
  logic [N_CH*CNT_W-1:0]   count;
  logic [N_CH*PRICE_W-1:0] spread;
  logic [TOT_W-1:0]        total;
  logic [3:0]              pc;
  logic [TOT_W:0]          sum;

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    trade_channel #(
      .PRICE_W   (PRICE_W),
      .CNT_W     (CNT_W),
      .HALT_LIMIT(HALT_LIMIT)
    ) u_ch (
      .clk        (clk),
      .reset      (reset),
      .order_valid(order_valid[i]),
      .buy_price  (buy_price[slice_lo(i, PRICE_W) +: PRICE_W]),
      .sell_price (sell_price[slice_lo(i, PRICE_W) +: PRICE_W]),
      .resume     (resume[i]),
      .inc        (inc[i]),
      .count      (count[slice_lo(i, CNT_W) +: CNT_W]),
      .spread     (spread[slice_lo(i, PRICE_W) +: PRICE_W]),
      .halt       (halt[i])
    );
  end

  assign pc  = popcount(8'(inc));
  assign sum = {1'b0, total} + (TOT_W+1)'(pc);

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      total <= '0;
    else
      total <= sum[TOT_W] ? '1 : sum[TOT_W-1:0];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      snap_count  <= '0;
      snap_spread <= '0;
      snap_halt   <= '0;
      snap_total  <= '0;
      snap_valid  <= 1'b0;
    end else begin
      snap_valid <= frame_start;
      if (frame_start) begin
        snap_count  <= count;
        snap_spread <= spread;
        snap_halt   <= halt;
        snap_total  <= total;
      end
    end
  end

endmodule
